// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP frame accumulator.
package dsp_pkg;

  localparam int unsigned DSP_P_W   = 48;
  localparam int unsigned DSP_LEN_DEF = 4;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } acc_state_e;

endpackage

// File: rtl/dsp_acc_dump_if.sv
// Sample input, frame-sum handshake and status signals of the frame accumulator.
interface dsp_acc_dump_if #(
  parameter int unsigned LEN = dsp_pkg::DSP_LEN_DEF,
  parameter int unsigned P_W = dsp_pkg::DSP_P_W
);
  localparam int unsigned SUM_W = P_W + $clog2(LEN);
  localparam int unsigned CNT_W = $clog2(LEN) + 1;

  logic             p_valid;
  logic [P_W-1:0]   p_data;
  logic             clr;
  logic             sum_valid;
  logic             sum_ready;
  logic [SUM_W-1:0] sum_data;
  logic [CNT_W-1:0] count;
  logic             overrun;

  modport master (
    output p_valid, p_data, clr, sum_ready,
    input  sum_valid, sum_data, count, overrun
  );

  modport slave (
    input  p_valid, p_data, clr, sum_ready,
    output sum_valid, sum_data, count, overrun
  );
endinterface

// File: rtl/dsp_acc_outreg.sv
// Frame-sum output register: valid/ready handshake with a sticky drop flag.
module dsp_acc_outreg #(
  parameter int unsigned SUM_W = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [SUM_W-1:0] load_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [SUM_W-1:0] data_o,
  output logic             overrun_o
);

  logic             valid_d, valid_q;
  logic [SUM_W-1:0] data_d, data_q;
  logic             overrun_d, overrun_q;
  logic             xfer;

  assign xfer = valid_q && ready_i;

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (load_i) begin
      // A completed frame only lands if the slot is empty or draining this edge.
      if (!valid_q || xfer) begin
        valid_d = 1'b1;
        data_d  = load_data_i;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/dsp_acc_dump.sv
// Accumulates LEN unsigned DSP products per frame and hands each frame sum downstream.
module dsp_acc_dump
  import dsp_pkg::*;
#(
  parameter int unsigned LEN = DSP_LEN_DEF,
  parameter int unsigned P_W = DSP_P_W
) (
  input  logic               clk,
  input  logic               rst,
  dsp_acc_dump_if.slave      bus
);

  localparam int unsigned SUM_W = P_W + $clog2(LEN);
  localparam int unsigned CNT_W = $clog2(LEN) + 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LEN - 1);

  acc_state_e       state_d, state_q;
  logic [SUM_W-1:0] acc_d, acc_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [SUM_W-1:0] sum_new;
  logic             done;

  assign sum_new = acc_q + SUM_W'(bus.p_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    done    = 1'b0;
    if (bus.clr) begin
      state_d = StIdle;
      acc_d   = '0;
      count_d = '0;
    end else if (bus.p_valid) begin
      unique case (state_q)
        StIdle: begin
          state_d = StAccum;
          acc_d   = SUM_W'(bus.p_data);
          count_d = CNT_W'(1);
        end
        StAccum: begin
          if (count_q == LastCnt) begin
            done    = 1'b1;
            state_d = StIdle;
            acc_d   = '0;
            count_d = '0;
          end else begin
            acc_d   = sum_new;
            count_d = count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign bus.count = count_q;

  dsp_acc_outreg #(
    .SUM_W (SUM_W)
  ) u_outreg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (done),
    .load_data_i (sum_new),
    .ready_i     (bus.sum_ready),
    .valid_o     (bus.sum_valid),
    .data_o      (bus.sum_data),
    .overrun_o   (bus.overrun)
  );

endmodule

// File: tb/tb_dsp_acc_dump.sv
// Scoreboard bench for dsp_acc_dump: expected frame sums queued at drive time, popped on transfer.
module tb_dsp_acc_dump;
  import dsp_pkg::*;

  localparam int unsigned LEN   = 4;
  localparam int unsigned P_W   = 48;
  localparam int unsigned SUM_W = P_W + $clog2(LEN);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_acc_dump_if #(.LEN(LEN), .P_W(P_W)) bus ();

  dsp_acc_dump #(.LEN(LEN), .P_W(P_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [SUM_W-1:0] sb_q[$];
  logic [SUM_W-1:0] m_acc, m_data;
  int               m_cnt;
  bit               m_valid, m_ovr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acc = '0; m_data = '0; m_cnt = 0; m_valid = 0; m_ovr = 0;
    sb_q.delete();
  endtask

  // Called at posedge+1: drives one cycle of stimulus and checks the result after the edge.
  task automatic step(input bit pv, input logic [P_W-1:0] pd, input bit c, input bit rdy);
    bit               xfer, done;
    logic [SUM_W-1:0] nsum;
    bus.p_valid = pv; bus.p_data = pd; bus.clr = c; bus.sum_ready = rdy;
    #1;
    xfer = m_valid && rdy;
    if (bus.sum_valid && rdy) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else chk("xfer_data", 64'(bus.sum_data), 64'(sb_q.pop_front()));
    end
    done = 0; nsum = '0;
    if (c) begin
      m_acc = '0; m_cnt = 0;
    end else if (pv) begin
      if (m_cnt == LEN - 1) begin
        done = 1; nsum = m_acc + SUM_W'(pd); m_acc = '0; m_cnt = 0;
      end else begin
        m_acc = m_acc + SUM_W'(pd); m_cnt++;
      end
    end
    if (done) begin
      if (!m_valid || xfer) begin
        m_valid = 1; m_data = nsum; sb_q.push_back(nsum);
      end else m_ovr = 1;
    end else if (xfer) m_valid = 0;
    @(posedge clk); #1;
    chk("count", 64'(bus.count), 64'(m_cnt));
    chk("sum_valid", 64'(bus.sum_valid), 64'(m_valid));
    chk("overrun", 64'(bus.overrun), 64'(m_ovr));
    if (m_valid) chk("held_data", 64'(bus.sum_data), 64'(m_data));
  endtask

  task automatic frame4(input logic [P_W-1:0] a, b, c, d, input bit rdy);
    step(1, a, 0, rdy); step(1, b, 0, rdy); step(1, c, 0, rdy); step(1, d, 0, rdy);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_valid", 64'(bus.sum_valid), 64'd0);
    chk("rst_data", 64'(bus.sum_data), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    model_clear();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    bus.p_valid = 0; bus.p_data = '0; bus.clr = 0; bus.sum_ready = 0;
    model_clear();
    #3;
    chk("init_count", 64'(bus.count), 64'd0);
    chk("init_valid", 64'(bus.sum_valid), 64'd0);
    chk("init_overrun", 64'(bus.overrun), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Basic frame, then idle cycle where the sum drains.
    frame4(1, 2, 3, 4, 1);
    chk("basic_sum", 64'(bus.sum_data), 64'd10);
    step(0, 0, 0, 1);
    chk("basic_drained", 64'(bus.sum_valid), 64'd0);

    // Max-value samples must not truncate.
    frame4(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1);
    chk("max_sum", 64'(bus.sum_data), 64'h3_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1);

    // Overrun: second frame dropped while output is held.
    frame4(1, 2, 3, 4, 0);
    frame4(5, 6, 7, 8, 0);
    chk("ovr_held", 64'(bus.sum_data), 64'd10);
    chk("ovr_flag", 64'(bus.overrun), 64'd1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("ovr_sticky", 64'(bus.overrun), 64'd1);

    // Simultaneous load and transfer.
    do_reset();
    frame4(1, 2, 3, 4, 0);
    step(1, 5, 0, 0); step(1, 6, 0, 0); step(1, 7, 0, 0); step(1, 8, 0, 1);
    chk("simul_sum", 64'(bus.sum_data), 64'd26);
    chk("simul_valid", 64'(bus.sum_valid), 64'd1);
    chk("simul_ovr", 64'(bus.overrun), 64'd0);
    step(0, 0, 0, 1);

    // clr beats p_valid mid-frame, with a gap before the fresh frame.
    step(1, 7, 0, 1); step(1, 7, 0, 1);
    step(1, 9, 1, 1);
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    frame4(1, 1, 1, 1, 1);
    chk("clr_sum", 64'(bus.sum_data), 64'd4);
    step(0, 0, 0, 1);

    // Reset mid-frame at count=2.
    step(1, 100, 0, 1); step(1, 200, 0, 1);
    do_reset();
    frame4(5, 6, 7, 8, 1);
    chk("rstmid_sum", 64'(bus.sum_data), 64'd26);
    step(0, 0, 0, 1);

    // Random traffic with gaps, clr and backpressure.
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 3) != 0), P_W'({$urandom(), $urandom()}),
           bit'($urandom_range(0, 30) == 0), bit'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("sb_leftover", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
